// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the AR-channel arbiter (state enum, master tags, payload bundle).
package axi_arb_pkg;

    localparam int TAG_BITS       = 4;
    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_IDS_BITS   = TAG_BITS + AXI_ID_BITS;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;

    localparam logic [TAG_BITS-1:0] TAG_M0 = 4'h0;
    localparam logic [TAG_BITS-1:0] TAG_M1 = 4'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]    id;
        logic [AXI_ADDR_BITS-1:0]  addr;
        logic [AXI_LEN_BITS-1:0]   len;
        logic [AXI_SIZE_BITS-1:0]  size;
        logic [AXI_BURST_BITS-1:0] burst;
    } ar_payload_t;

endpackage

// File: rtl/axi_arb_pick.sv
// Two-way request picker. AXI_ARB_RR_EN selects round-robin (tie goes to the master
// not granted last); otherwise fixed priority with M1 winning ties.
module axi_arb_pick (
    input  logic req_m0,
    input  logic req_m1,
`ifdef AXI_ARB_RR_EN
    input  logic last_m1,
`endif
    output logic pick_m1
);

`ifdef AXI_ARB_RR_EN
    assign pick_m1 = req_m1 & (~req_m0 | ~last_m1);
`else
    assign pick_m1 = req_m1;
`endif

endmodule

// File: rtl/axi_ar_arbiter.sv
// AR-channel arbiter between M0 (instruction) and M1 (data); grant held until the last R beat.
// AXI_ARB_RR_EN enables round-robin arbitration, otherwise fixed priority (M1 wins ties).
module axi_ar_arbiter
    import axi_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_BITS-1:0]    ARID_M0,
    input  logic [AXI_ADDR_BITS-1:0]  ARADDR_M0,
    input  logic [AXI_LEN_BITS-1:0]   ARLEN_M0,
    input  logic [AXI_SIZE_BITS-1:0]  ARSIZE_M0,
    input  logic [AXI_BURST_BITS-1:0] ARBURST_M0,
    input  logic                      ARVALID_M0,
    output logic                      ARREADY_M0,
    input  logic [AXI_ID_BITS-1:0]    ARID_M1,
    input  logic [AXI_ADDR_BITS-1:0]  ARADDR_M1,
    input  logic [AXI_LEN_BITS-1:0]   ARLEN_M1,
    input  logic [AXI_SIZE_BITS-1:0]  ARSIZE_M1,
    input  logic [AXI_BURST_BITS-1:0] ARBURST_M1,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M1,
    output logic [AXI_IDS_BITS-1:0]   ARID_S,
    output logic [AXI_ADDR_BITS-1:0]  ARADDR_S,
    output logic [AXI_LEN_BITS-1:0]   ARLEN_S,
    output logic [AXI_SIZE_BITS-1:0]  ARSIZE_S,
    output logic [AXI_BURST_BITS-1:0] ARBURST_S,
    output logic                      VALID_S,
    input  logic                      READY_S,
    input  logic                      RVALID_S,
    input  logic                      RREADY_S,
    input  logic                      RLAST_S,
    output logic                      GRANT_M1
);

    arb_state_e  state_reg, state_next;
    logic        grant_m1_reg, grant_m1_next;
    logic        pick_m1;
    ar_payload_t pay_m   [2];
    logic        valid_m [2];
    logic        ready_m [2];
    ar_payload_t gnt_pay;
    logic        gnt_valid;
    ar_payload_t out_pay;
    logic [TAG_BITS-1:0] out_tag;
    logic        valid_s;

    assign pay_m[0]   = {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
    assign pay_m[1]   = {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};
    assign valid_m[0] = ARVALID_M0;
    assign valid_m[1] = ARVALID_M1;

    assign gnt_pay   = pay_m[grant_m1_reg];
    assign gnt_valid = valid_m[grant_m1_reg];

`ifdef AXI_ARB_RR_EN
    // Last granted master; starts at M1 so M0 wins the first tie after reset.
    logic last_m1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_m1_reg <= 1'b1;
        end else if (state_reg == IDLE && state_next == ADDR) begin
            last_m1_reg <= pick_m1;
        end
    end

    axi_arb_pick u_pick (
        .req_m0  (ARVALID_M0),
        .req_m1  (ARVALID_M1),
        .last_m1 (last_m1_reg),
        .pick_m1 (pick_m1)
    );
`else
    axi_arb_pick u_pick (
        .req_m0  (ARVALID_M0),
        .req_m1  (ARVALID_M1),
        .pick_m1 (pick_m1)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_m1_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_m1_reg <= grant_m1_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_m1_next = grant_m1_reg;
        valid_s       = 1'b0;
        out_pay       = '0;
        out_tag       = '0;
        case (state_reg)
            IDLE: begin
                if (ARVALID_M0 | ARVALID_M1) begin
                    grant_m1_next = pick_m1;
                    state_next    = ADDR;
                end
            end
            ADDR: begin
                valid_s = gnt_valid;
                out_pay = gnt_pay;
                out_tag = grant_m1_reg ? TAG_M1 : TAG_M0;
                // A master withdrawing its request releases the slot without a transfer.
                if (!gnt_valid) begin
                    state_next = IDLE;
                end else if (READY_S) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (RVALID_S & RREADY_S & RLAST_S) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_m[gi] = READY_S & valid_s & (grant_m1_reg == 1'(gi));
        end
    endgenerate

    assign ARREADY_M0 = ready_m[0];
    assign ARREADY_M1 = ready_m[1];
    assign ARID_S     = {out_tag, out_pay.id};
    assign ARADDR_S   = out_pay.addr;
    assign ARLEN_S    = out_pay.len;
    assign ARSIZE_S   = out_pay.size;
    assign ARBURST_S  = out_pay.burst;
    assign VALID_S    = valid_s;
    assign GRANT_M1   = grant_m1_reg & (state_reg != IDLE);

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Self-checking bench for axi_ar_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_axi_ar_arbiter;

`ifdef AXI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_m    [2];
    logic [31:0] addr_m  [2];
    logic [3:0]  len_m   [2];
    logic [2:0]  size_m  [2];
    logic [1:0]  burst_m [2];
    logic        valid_m [2];
    logic        ready_s, rvalid_s, rready_s, rlast_s;

    logic        arready_m0, arready_m1;
    logic [7:0]  arid_s;
    logic [31:0] araddr_s;
    logic [3:0]  arlen_s;
    logic [2:0]  arsize_s;
    logic [1:0]  arburst_s;
    logic        valid_s, grant_m1;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase 0 = no owner, 1 = address offered, 2 = waiting for last beat.
    int ph;
    bit own;
    bit last_own;

    always #5 clk = ~clk;

    axi_ar_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ARID_M0    (id_m[0]),
        .ARADDR_M0  (addr_m[0]),
        .ARLEN_M0   (len_m[0]),
        .ARSIZE_M0  (size_m[0]),
        .ARBURST_M0 (burst_m[0]),
        .ARVALID_M0 (valid_m[0]),
        .ARREADY_M0 (arready_m0),
        .ARID_M1    (id_m[1]),
        .ARADDR_M1  (addr_m[1]),
        .ARLEN_M1   (len_m[1]),
        .ARSIZE_M1  (size_m[1]),
        .ARBURST_M1 (burst_m[1]),
        .ARVALID_M1 (valid_m[1]),
        .ARREADY_M1 (arready_m1),
        .ARID_S     (arid_s),
        .ARADDR_S   (araddr_s),
        .ARLEN_S    (arlen_s),
        .ARSIZE_S   (arsize_s),
        .ARBURST_S  (arburst_s),
        .VALID_S    (valid_s),
        .READY_S    (ready_s),
        .RVALID_S   (rvalid_s),
        .RREADY_S   (rready_s),
        .RLAST_S    (rlast_s),
        .GRANT_M1   (grant_m1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        own = 1'b0;
        last_own = 1'b1;
    endtask

    task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        id_m[m]    = id;
        addr_m[m]  = addr;
        len_m[m]   = len;
        size_m[m]  = size;
        burst_m[m] = burst;
        valid_m[m] = 1'b1;
    endtask

    // Compare every DUT output with the model's view of the current cycle.
    task automatic check();
        logic        ev, er0, er1, eg;
        logic [7:0]  eid;
        logic [31:0] ea;
        logic [3:0]  el;
        logic [2:0]  es;
        logic [1:0]  eb;
        ev = 0; er0 = 0; er1 = 0; eg = 0; eid = 0; ea = 0; el = 0; es = 0; eb = 0;
        if (ph == 1) begin
            ev  = valid_m[own];
            eid = {3'b000, own, id_m[own]};
            ea  = addr_m[own];
            el  = len_m[own];
            es  = size_m[own];
            eb  = burst_m[own];
            er0 = ev & ready_s & (own == 1'b0);
            er1 = ev & ready_s & (own == 1'b1);
        end
        if (ph != 0) eg = own;
        #1;
        chk("VALID_S", valid_s, ev);
        chk("ARREADY_M0", arready_m0, er0);
        chk("ARREADY_M1", arready_m1, er1);
        chk("GRANT_M1", grant_m1, eg);
        chk("ARID_S", arid_s, eid);
        chk("PAYLOAD", {araddr_s, arlen_s, arsize_s, arburst_s}, {ea, el, es, eb});
    endtask

    // Advance the model with the inputs held across the edge, then move past the edge.
    task automatic tick();
        bit vs;
        vs = (ph == 1) && valid_m[own];
        case (ph)
            0: if (valid_m[0] || valid_m[1]) begin
                   if (valid_m[0] && valid_m[1]) own = RR ? !last_own : 1'b1;
                   else                          own = valid_m[1];
                   last_own = own;
                   ph = 1;
               end
            1: if (!vs) ph = 0; else if (ready_s) ph = 2;
            2: if (rvalid_s && rready_s && rlast_s) ph = 0;
            default: ph = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit last);
        rvalid_s = 1'b1; rready_s = 1'b1; rlast_s = last;
        check();
        tick();
        rvalid_s = 1'b0; rready_s = 1'b0; rlast_s = 1'b0;
    endtask

    initial begin
        bit exp_g;
        bit hs0, hs1;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            id_m[m] = 0; addr_m[m] = 0; len_m[m] = 0; size_m[m] = 0; burst_m[m] = 0; valid_m[m] = 0;
        end
        ready_s = 0; rvalid_s = 0; rready_s = 0; rlast_s = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check();
        rst = 1'b0;

        // M0 alone, 4-beat burst, READY_S already high.
        set_req(0, 4'h5, 32'h0000_0040, 4'd3, 3'd2, 2'd1);
        ready_s = 1'b1;
        check();
        tick();
        check();
        chk("T1_ARREADY_M0", arready_m0, 1'b1);
        chk("T1_ARID_S", arid_s, 8'h05);
        tick();
        valid_m[0] = 1'b0;
        ready_s = 1'b0;
        set_req(1, 4'h3, 32'h0002_0000, 4'd0, 3'd2, 2'd1);
        for (int b = 0; b < 4; b++) begin
            chk("T1_LOCK_HELD", valid_s, 1'b0);
            beat(b == 3);
        end
        check();
        tick();

        // M1 to the default-slave region, READY_S held low for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            check();
            chk("T2_VALID_HELD", valid_s, 1'b1);
            chk("T2_ADDR_STABLE", araddr_s, 32'h0002_0000);
            chk("T2_NO_READY", arready_m1, 1'b0);
            tick();
        end
        ready_s = 1'b1;
        check();
        chk("T2_ARREADY_M1", arready_m1, 1'b1);
        chk("T2_ARID_S", arid_s, 8'h13);
        tick();
        valid_m[1] = 1'b0;
        ready_s = 1'b0;
        beat(1'b1);
        check();
        tick();

        // Reset pulsed in the middle of a burst, then a fresh request.
        set_req(0, 4'hA, 32'h0000_1000, 4'd7, 3'd2, 2'd1);
        ready_s = 1'b1;
        check(); tick();
        check(); tick();
        valid_m[0] = 1'b0;
        ready_s = 1'b0;
        set_req(1, 4'h6, 32'h0000_2000, 4'd1, 3'd2, 2'd1);
        beat(1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("T3_RST_VALID_S", valid_s, 1'b0);
        chk("T3_RST_GRANT_M1", grant_m1, 1'b0);
        chk("T3_RST_ARID_S", arid_s, 8'h00);
        #2;
        rst = 1'b0;
        check();
        tick();
        ready_s = 1'b1;
        check();
        chk("T3_NEW_REQ", arready_m1, 1'b1);
        tick();
        valid_m[1] = 1'b0;
        ready_s = 1'b0;
        beat(1'b1);

        // Both masters request continuously; grant order depends on the arbitration mode.
        set_req(0, 4'h1, 32'h0000_0100, 4'd0, 3'd2, 2'd1);
        set_req(1, 4'h2, 32'h0000_0200, 4'd0, 3'd2, 2'd1);
        for (int k = 0; k < 4; k++) begin
            check();
            tick();
            exp_g = RR ? ((k % 2) == 1) : 1'b1;
            check();
            chk("T4_TIE_GRANT", grant_m1, exp_g);
            ready_s = 1'b1;
            check();
            tick();
            ready_s = 1'b0;
            beat(1'b1);
        end
        valid_m[0] = 1'b0;
        valid_m[1] = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!valid_m[m] && ($urandom_range(0, 2) == 0))
                    set_req(m, 4'($urandom), $urandom, 4'($urandom), 3'($urandom), 2'($urandom));
                else if (valid_m[m] && ($urandom_range(0, 15) == 0))
                    valid_m[m] = 1'b0;
            end
            ready_s  = 1'($urandom_range(0, 1));
            rvalid_s = 1'($urandom_range(0, 1));
            rready_s = 1'($urandom_range(0, 1));
            rlast_s  = ($urandom_range(0, 2) == 0);
            check();
            hs0 = (ph == 1) && (own == 1'b0) && valid_m[0] && ready_s;
            hs1 = (ph == 1) && (own == 1'b1) && valid_m[1] && ready_s;
            tick();
            if (hs0) valid_m[0] = 1'b0;
            if (hs1) valid_m[1] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
